sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO, the successor to the fixed 16-deep FIFO. It adds configurable width, depth and almost-full/almost-empty thresholds, an exported occupancy count, and per-cycle overflow/underflow error pulses. It sits between a single-clock producer and consumer. It exposes `fifo_cnt` so that property checkers and upstream flow control can observe occupancy directly.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AF_THRESH`, DEPTH-2: `fifo_almost_full` asserts when count ≥ this value; range 1..DEPTH.
- `AE_THRESH`, 2: `fifo_almost_empty` asserts when count ≤ this value; range 0..DEPTH-1.

Ports. One clock; reset is asynchronous and active-low.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_` input 1: asynchronous active-low reset.
- `fifo_write` input 1: write request.
- `fifo_read` input 1: read request.
- `fifo_data_in` input DATA_WIDTH: write data.
- `fifo_data_out` output DATA_WIDTH: registered read data.
- `fifo_full` output 1: count == DEPTH.
- `fifo_empty` output 1: count == 0.
- `fifo_almost_full` output 1: count ≥ AF_THRESH.
- `fifo_almost_empty` output 1: count ≤ AE_THRESH.
- `fifo_cnt` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `fifo_overflow` output 1: one-cycle pulse when a write is rejected.
- `fifo_underflow` output 1: one-cycle pulse when a read is rejected.

## Operation
- **State:** write pointer `wr_ptr`, read pointer `rd_ptr` (each $clog2(DEPTH) bits, wrap modulo DEPTH), count register, and storage array.
- **Accepted write:** `fifo_write && !fifo_full`. Stores `fifo_data_in` at `wr_ptr`, then `wr_ptr` increments.
- **Rejected write:** `fifo_write && fifo_full && !fifo_read`. Storage and pointers are unchanged; `fifo_overflow` pulses on the next cycle.
- **Accepted read:** `fifo_read && !fifo_empty`. `fifo_data_out` loads the entry at `rd_ptr`, then `rd_ptr` increments.
- **Rejected read:** `fifo_read && fifo_empty`. `fifo_underflow` pulses; `fifo_data_out` holds.
- **Read and write when empty:** the write is accepted and the read is rejected (underflow pulses). There is no bypass.
- **Read and write when full:** both are accepted, count is unchanged, no overflow.
- **Read and write, 0 < count < DEPTH:** both are accepted, count is unchanged.
- **Count update:** +1 on accepted write only, −1 on accepted read only, otherwise unchanged.
- **Status flags:** all status outputs are decoded combinationally from the count register, so they are glitch-free relative to `clk`.
- **`fifo_data_out` hold:** holds its last value when no read is accepted.
- **Reset value of every output:** while `rst_` is low, pointers = 0, count = 0, `fifo_data_out` = 0, `fifo_full` = 0, `fifo_empty` = 1, `fifo_almost_empty` = 1, `fifo_almost_full` = 0 (given AF_THRESH ≥ 1), `fifo_overflow` = 0, `fifo_underflow` = 0. Storage contents are not reset.
- **Reset mid-operation:** all queued data is discarded and the block is in the reset state on the first edge after `rst_` deasserts.

## Timing
- **Write-to-read latency:** a word written at edge N is readable at edge N+1. It appears on `fifo_data_out` after the edge at which the read is accepted, so read latency is 1 cycle.
- **Flags and count:** `fifo_cnt` and all flags reflect the requests sampled at edge N immediately after edge N.
- **Error pulses:** `fifo_overflow` and `fifo_underflow` are registered, high for exactly the one cycle after the offending edge.
- **Reset release:** `rst_` is asynchronous on assertion; deassertion is assumed synchronised externally.

## Configuration
- **`SYNC_FIFO_ASSERT_EN` defined:** the module compiles embedded concurrent assertions, all disabled while `rst_` is low:
  - reset state as listed above;
  - `fifo_cnt == 0` ↔ `fifo_empty`;
  - `fifo_cnt == DEPTH` ↔ `fifo_full`;
  - `fifo_cnt` never exceeds DEPTH;
  - `fifo_full` and `fifo_empty` are never both high;
  - the count changes by at most 1 per cycle.
  
  Each failure reports `$stime` and the property name via `$error`.
- **`SYNC_FIFO_ASSERT_EN` undefined:** no assertion code is compiled and the RTL behaviour is identical.

## Structure
- **Package `sync_fifo_pkg`:**
  - default-value constants: `SF_DEF_WIDTH` = 8, `SF_DEF_DEPTH` = 16;
  - a function returning the count width for a given depth.
- **Sub-module `sync_fifo_mem`:** simple dual-port array with one synchronous write port and one synchronous registered read port, parametrised by DATA_WIDTH/DEPTH.
- **Top level:** holds pointers, count, flag decode, error pulses and the optional assertions.

## Test plan
- **Reset:** assert `rst_` with `fifo_write` = 1 → `fifo_empty` = 1, `fifo_full` = 0, `fifo_cnt` = 0, `fifo_data_out` = 0, no pulses.
- **Fill and overflow:** DEPTH = 16; write 0x00..0x0F → `fifo_full` = 1, `fifo_cnt` = 16. `fifo_almost_full` first rises after the 14th write. A 17th write → `fifo_overflow` pulses once and `fifo_cnt` stays 16.
- **Drain and underflow:** from full, read 16 times → outputs 0x00..0x0F in order, `fifo_empty` = 1. A 17th read → `fifo_underflow` pulses and `fifo_data_out` holds 0x0F.
- **Simultaneous read/write:**
  - at count 5: read+write for 20 cycles → `fifo_cnt` stays 5 and data order is preserved across pointer wrap;
  - when full: read+write → no overflow, count stays 16;
  - when empty: read+write → underflow pulses, count becomes 1.
- **Non-default parameters:** DATA_WIDTH = 32, DEPTH = 4, AF_THRESH = 3, AE_THRESH = 0 → `fifo_almost_empty` = 1 only at count 0, `fifo_almost_full` = 1 at counts 3–4, `fifo_cnt` is 3 bits wide.
- **Reset mid-operation:** write 7 words, pulse `rst_` low for one cycle → `fifo_cnt` = 0, `fifo_empty` = 1. A following write/read returns the new word, not stale data.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module  : sync_fifo_pkg
// Desc    : Shared defaults and the count-width helper for the sync FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

  localparam int SF_DEF_WIDTH = 8;
  localparam int SF_DEF_DEPTH = 16;

  // The count must also represent the completely full value, hence one extra bit.
  function automatic int sf_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module  : sync_fifo_mem
// Desc    : Simple dual-port storage with a synchronous write port and a
//           registered read port that holds its value when not enabled.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0]    o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module  : sync_fifo_param
// Desc    : Parametrised single-clock FIFO with occupancy count, threshold
//           flags and overflow/underflow pulses. Define SYNC_FIFO_ASSERT_EN
//           to compile the embedded concurrent assertions.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SF_DEF_WIDTH,
  parameter int DEPTH      = SF_DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   fifo_write,
  input  logic                   fifo_read,
  input  logic [DATA_WIDTH-1:0]  fifo_data_in,
  output logic [DATA_WIDTH-1:0]  fifo_data_out,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   fifo_almost_full,
  output logic                   fifo_almost_empty,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   fifo_overflow,
  output logic                   fifo_underflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = sf_cnt_width(DEPTH);

  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(AF_THRESH);
  localparam logic [c_CNT_W-1:0] c_AE_CNT   = c_CNT_W'(AE_THRESH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_overflow;
  logic               r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full  = (r_cnt == c_FULL_CNT);
  assign w_empty = (r_cnt == '0);

  // A full FIFO still takes a write when a read frees the slot on the same edge.
  assign w_wr_acc = fifo_write && (!w_full || fifo_read);
  assign w_rd_acc = fifo_read && !w_empty;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= fifo_write && w_full && !fifo_read;
      r_underflow <= fifo_read && w_empty;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_      (rst_),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (fifo_data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (fifo_data_out)
  );

  assign fifo_cnt          = r_cnt;
  assign fifo_full         = w_full;
  assign fifo_empty        = w_empty;
  assign fifo_almost_full  = (r_cnt >= c_AF_CNT);
  assign fifo_almost_empty = (r_cnt <= c_AE_CNT);
  assign fifo_overflow     = r_overflow;
  assign fifo_underflow    = r_underflow;

`ifdef SYNC_FIFO_ASSERT_EN
  a_reset_state: assert property (@(posedge clk)
    $rose(rst_) |-> ((fifo_cnt == '0) && fifo_empty && !fifo_full && fifo_almost_empty
                     && !fifo_almost_full && !fifo_overflow && !fifo_underflow
                     && (fifo_data_out == '0) && (r_wr_ptr == '0) && (r_rd_ptr == '0)))
    else $error("%0d a_reset_state", $stime);

  a_empty_iff_zero: assert property (@(posedge clk) disable iff (!rst_)
    (fifo_cnt == '0) == fifo_empty)
    else $error("%0d a_empty_iff_zero", $stime);

  a_full_iff_depth: assert property (@(posedge clk) disable iff (!rst_)
    (fifo_cnt == c_FULL_CNT) == fifo_full)
    else $error("%0d a_full_iff_depth", $stime);

  a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_)
    fifo_cnt <= c_FULL_CNT)
    else $error("%0d a_cnt_bounded", $stime);

  a_not_full_and_empty: assert property (@(posedge clk) disable iff (!rst_)
    !(fifo_full && fifo_empty))
    else $error("%0d a_not_full_and_empty", $stime);

  a_cnt_step: assert property (@(posedge clk) disable iff (!rst_)
    (fifo_cnt == $past(fifo_cnt)) || (fifo_cnt == $past(fifo_cnt) + c_CNT_ONE)
    || (fifo_cnt + c_CNT_ONE == $past(fifo_cnt)))
    else $error("%0d a_cnt_step", $stime);
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a default 16x8 instance and a 4x32 instance share
// stimulus and are compared every cycle against queue-based reference models.
`default_nettype none

module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] din = '0;

  logic [7:0]  dout16;
  logic        full16, empty16, af16, ae16, ovf16, unf16;
  logic [4:0]  cnt16;
  logic [31:0] dout4;
  logic        full4, empty4, af4, ae4, ovf4, unf4;
  logic [2:0]  cnt4;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param u_dut16 (
    .clk(clk), .rst_(rst_), .fifo_write(wr), .fifo_read(rd), .fifo_data_in(din[7:0]),
    .fifo_data_out(dout16), .fifo_full(full16), .fifo_empty(empty16),
    .fifo_almost_full(af16), .fifo_almost_empty(ae16), .fifo_cnt(cnt16),
    .fifo_overflow(ovf16), .fifo_underflow(unf16)
  );

  sync_fifo_param #(.DATA_WIDTH(32), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(0)) u_dut4 (
    .clk(clk), .rst_(rst_), .fifo_write(wr), .fifo_read(rd), .fifo_data_in(din),
    .fifo_data_out(dout4), .fifo_full(full4), .fifo_empty(empty4),
    .fifo_almost_full(af4), .fifo_almost_empty(ae4), .fifo_cnt(cnt4),
    .fifo_overflow(ovf4), .fifo_underflow(unf4)
  );

  // Reference models: a queue holds the contents, the rest follows from its size.
  logic [7:0]  q16[$];
  logic [31:0] q4[$];
  logic [7:0]  m_dout16;
  logic [31:0] m_dout4;
  logic        m_ovf16, m_unf16, m_ovf4, m_unf4;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      q16.delete();
      q4.delete();
      m_dout16 <= '0;
      m_dout4  <= '0;
      m_ovf16  <= 1'b0;
      m_unf16  <= 1'b0;
      m_ovf4   <= 1'b0;
      m_unf4   <= 1'b0;
    end else begin
      m_ovf16 <= wr && (q16.size() == 16) && !rd;
      m_unf16 <= rd && (q16.size() == 0);
      if (rd && q16.size() != 0) m_dout16 <= q16.pop_front();
      if (wr && (q16.size() < 16 || rd)) q16.push_back(din[7:0]);
      m_ovf4 <= wr && (q4.size() == 4) && !rd;
      m_unf4 <= rd && (q4.size() == 0);
      if (rd && q4.size() != 0) m_dout4 <= q4.pop_front();
      if (wr && (q4.size() < 4 || rd)) q4.push_back(din);
    end
  end

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cnt16",   cnt16,   q16.size());
      chk("full16",  full16,  q16.size() == 16);
      chk("empty16", empty16, q16.size() == 0);
      chk("af16",    af16,    q16.size() >= 14);
      chk("ae16",    ae16,    q16.size() <= 2);
      chk("dout16",  dout16,  m_dout16);
      chk("ovf16",   ovf16,   m_ovf16);
      chk("unf16",   unf16,   m_unf16);
      chk("cnt4",    cnt4,    q4.size());
      chk("full4",   full4,   q4.size() == 4);
      chk("empty4",  empty4,  q4.size() == 0);
      chk("af4",     af4,     q4.size() >= 3);
      chk("ae4",     ae4,     q4.size() == 0);
      chk("dout4",   dout4,   m_dout4);
      chk("ovf4",    ovf4,    m_ovf4);
      chk("unf4",    unf4,    m_unf4);
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    @(negedge clk);
    #1;
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1;
    rst_ = 1'b0;
    wr   = 1'b1;
    rd   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_cnt16", cnt16, 0);
    chk("rst_empty16", empty16, 1);
    chk("rst_full16", full16, 0);
    chk("rst_dout16", dout16, 0);
    chk("rst_pulses16", {ovf16, unf16}, 0);
    chk("rst_ae_af4", {ae4, af4}, 2'b10);
    @(negedge clk);
    #1;
    wr   = 1'b0;
    rst_ = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    do_reset(2);

    // Fill the 16-deep FIFO; the 4-deep one fills and then overflows.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 32'(i));
      if (i == 0)  chk("ae4_after1", ae4, 0);
      if (i == 1)  chk("af4_after2", af4, 0);
      if (i == 2)  chk("af4_after3", af4, 1);
      if (i == 12) chk("af16_after13", af16, 0);
      if (i == 13) chk("af16_after14", af16, 1);
    end
    chk("fill_full16", full16, 1);
    chk("fill_cnt16", cnt16, 16);
    cyc(1'b1, 1'b0, 32'hAA);
    chk("ovf16_pulse", ovf16, 1);
    chk("ovf_cnt16", cnt16, 16);
    cyc(1'b0, 1'b0, 32'h0);
    chk("ovf16_once", ovf16, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      chk("drain_dout16", dout16, i);
    end
    chk("drain_empty16", empty16, 1);
    cyc(1'b0, 1'b1, 32'h0);
    chk("unf16_pulse", unf16, 1);
    chk("unf16_hold", dout16, 8'h0F);

    // Read+write while empty: write lands, read is rejected.
    cyc(1'b1, 1'b1, 32'h55);
    chk("rw_empty_unf16", unf16, 1);
    chk("rw_empty_cnt16", cnt16, 1);
    for (int i = 1; i < 5; i++) cyc(1'b1, 1'b0, 32'(8'h55 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 32'(8'h60 + i));
      chk("rw5_cnt16", cnt16, 5);
      chk("rw5_dout16", dout16, (i < 5) ? (8'h55 + i) : (8'h60 + i - 5));
    end

    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 32'(8'h80 + i));
    chk("refill_full16", full16, 1);
    cyc(1'b1, 1'b1, 32'h99);
    chk("rw_full_ovf16", ovf16, 0);
    chk("rw_full_cnt16", cnt16, 16);

    // Reset mid-operation discards queued words.
    do_reset(1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 32'(8'h70 + i));
    chk("pre_rst_cnt16", cnt16, 7);
    cyc(1'b0, 1'b0, 32'h0);
    do_reset(1);
    cyc(1'b1, 1'b0, 32'hC3);
    cyc(1'b0, 1'b1, 32'h0);
    chk("post_rst_dout16", dout16, 8'hC3);

    // Randomised traffic in phases biased toward fill, drain and balance.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      logic w, r;
      ph = (i / 150) % 3;
      w = ($urandom_range(99) < ((ph == 0) ? 75 : (ph == 1) ? 25 : 50));
      r = ($urandom_range(99) < ((ph == 0) ? 25 : (ph == 1) ? 75 : 50));
      if ($urandom_range(499) == 0) do_reset(1);
      else cyc(w, r, $urandom);
    end

    cyc(1'b0, 1'b0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
